// File: rtl/knn_ctrl.sv
// knn_ctrl: sequences training points through dist_core and keeps a sorted K-nearest list.
// Optional majority vote over the kept labels is enabled with `define KNN_CTRL_VOTE_EN.
module knn_ctrl #(
    parameter int DATA_W  = 16,
    parameter int DIST_W  = 32,
    parameter int LABEL_W = 8,
    parameter int K       = 4,
    localparam int IDX_W  = (K > 1) ? $clog2(K) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        npoints,
    input  logic [DATA_W-1:0]  test_x,
    input  logic [DATA_W-1:0]  test_y,
    input  logic               pt_valid,
    output logic               pt_ready,
    input  logic [DATA_W-1:0]  pt_x,
    input  logic [DATA_W-1:0]  pt_y,
    input  logic [LABEL_W-1:0] pt_label,
    output logic [DATA_W-1:0]  dist_ax,
    output logic [DATA_W-1:0]  dist_bx,
    output logic [DATA_W-1:0]  dist_ay,
    output logic [DATA_W-1:0]  dist_by,
    input  logic [DIST_W-1:0]  dist_in,
    output logic               busy,
    output logic               done,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [DIST_W-1:0]  rd_dist,
    output logic [LABEL_W-1:0] rd_label,
    output logic               rd_valid,
    output logic [2:0]         state_dbg
`ifdef KNN_CTRL_VOTE_EN
    ,
    output logic [LABEL_W-1:0] class_out
`endif
);

    // Handshake: a training point transfers on the rising edge where pt_valid && pt_ready.
    // pt_ready is registered and high only in WAIT; pt_valid may be raised at any time.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_DIST   = 3'd3,
        S_INSERT = 3'd4,
        S_DONE   = 3'd5
`ifdef KNN_CTRL_VOTE_EN
        ,
        S_VOTE   = 3'd6
`endif
    } state_t;

    state_t              state;
    logic [15:0]         npoints_r;
    logic [15:0]         pt_cnt;
    logic [LABEL_W-1:0]  pt_label_r;
    logic [DIST_W-1:0]   d_reg;

    logic [K-1:0]        slot_v;
    logic [DIST_W-1:0]   slot_d [K];
    logic [LABEL_W-1:0]  slot_l [K];

    logic                ins_hit;
    logic [IDX_W-1:0]    ins_pos;
    logic                last_pt;

    assign state_dbg = state;
    assign last_pt   = (({1'b0, pt_cnt} + 17'd1) == {1'b0, npoints_r});

    // First slot that is empty or strictly farther than the new point.
    always_comb begin
        ins_hit = 1'b0;
        ins_pos = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (!slot_v[i] || (d_reg < slot_d[i])) begin
                ins_hit = 1'b1;
                ins_pos = IDX_W'(i);
            end
        end
    end

    always_comb begin
        rd_valid = 1'b0;
        rd_dist  = '0;
        rd_label = '0;
        if (int'(rd_idx) < K) begin
            rd_valid = slot_v[rd_idx];
            rd_dist  = slot_d[rd_idx];
            rd_label = slot_l[rd_idx];
        end
    end

`ifdef KNN_CTRL_VOTE_EN
    localparam int CNT_W = $clog2(K + 1);
    logic [IDX_W-1:0] vote_j;
    logic [CNT_W-1:0] vote_cnt;
    logic [CNT_W-1:0] best_cnt;

    always_comb begin
        vote_cnt = '0;
        for (int i = 0; i < K; i++) begin
            if (slot_v[i] && (slot_l[i] == slot_l[vote_j])) begin
                vote_cnt = vote_cnt + CNT_W'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pt_ready   <= 1'b0;
            npoints_r  <= '0;
            pt_cnt     <= '0;
            pt_label_r <= '0;
            d_reg      <= '0;
            dist_ax    <= '0;
            dist_ay    <= '0;
            dist_bx    <= '0;
            dist_by    <= '0;
            slot_v     <= '0;
            for (int i = 0; i < K; i++) begin
                slot_d[i] <= '1;
                slot_l[i] <= '0;
            end
`ifdef KNN_CTRL_VOTE_EN
            vote_j    <= '0;
            best_cnt  <= '0;
            class_out <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        npoints_r <= npoints;
                        dist_ax   <= test_x;
                        dist_ay   <= test_y;
`ifdef KNN_CTRL_VOTE_EN
                        class_out <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    slot_v <= '0;
                    for (int i = 0; i < K; i++) begin
                        slot_d[i] <= '1;
                        slot_l[i] <= '0;
                    end
                    pt_cnt <= '0;
                    if (npoints_r == 16'd0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_WAIT;
                        pt_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (pt_valid) begin
                        state      <= S_DIST;
                        pt_ready   <= 1'b0;
                        dist_bx    <= pt_x;
                        dist_by    <= pt_y;
                        pt_label_r <= pt_label;
                    end
                end
                S_DIST: begin
                    d_reg <= dist_in;
                    state <= S_INSERT;
                end
                S_INSERT: begin
                    if (ins_hit) begin
                        if (ins_pos == '0) begin
                            slot_v[0] <= 1'b1;
                            slot_d[0] <= d_reg;
                            slot_l[0] <= pt_label_r;
                        end
                        for (int i = 1; i < K; i++) begin
                            if (IDX_W'(i) == ins_pos) begin
                                slot_v[i] <= 1'b1;
                                slot_d[i] <= d_reg;
                                slot_l[i] <= pt_label_r;
                            end else if (IDX_W'(i) > ins_pos) begin
                                slot_v[i] <= slot_v[i-1];
                                slot_d[i] <= slot_d[i-1];
                                slot_l[i] <= slot_l[i-1];
                            end
                        end
                    end
                    pt_cnt <= pt_cnt + 16'd1;
                    if (last_pt) begin
`ifdef KNN_CTRL_VOTE_EN
                        state    <= S_VOTE;
                        vote_j   <= '0;
                        best_cnt <= '0;
`else
                        state <= S_DONE;
                        done  <= 1'b1;
`endif
                    end else begin
                        state    <= S_WAIT;
                        pt_ready <= 1'b1;
                    end
                end
`ifdef KNN_CTRL_VOTE_EN
                S_VOTE: begin
                    // Strict '>' keeps the nearer slot's label on a count tie.
                    if (slot_v[vote_j] && (vote_cnt > best_cnt)) begin
                        best_cnt  <= vote_cnt;
                        class_out <= slot_l[vote_j];
                    end
                    if (vote_j == IDX_W'(K - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        vote_j <= vote_j + IDX_W'(1);
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    pt_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_ctrl.sv
// Directed bench for knn_ctrl: stimulus pushes expected slot lists, a monitor checks them on done.
module tb_knn_ctrl;
    localparam int K  = 4;
    localparam int W  = 1 + 32 + 8;
`ifdef KNN_CTRL_VOTE_EN
    localparam int VD = K;
`else
    localparam int VD = 0;
`endif
    localparam logic [W-1:0] EMPTY = {1'b0, 32'hFFFF_FFFF, 8'h00};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] npoints = '0;
    logic [15:0] test_x = '0, test_y = '0;
    logic        pt_valid = 1'b0;
    logic        pt_ready;
    logic [15:0] pt_x = '0, pt_y = '0;
    logic [7:0]  pt_label = '0;
    logic [15:0] dist_ax, dist_bx, dist_ay, dist_by;
    logic [31:0] dist_in;
    logic        busy, done;
    logic [1:0]  rd_idx = '0;
    logic [31:0] rd_dist;
    logic [7:0]  rd_label;
    logic        rd_valid;
    logic [2:0]  state_dbg;
`ifdef KNN_CTRL_VOTE_EN
    logic [7:0]  class_out;
    logic [7:0]  exp_cls[$];
`endif

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int req_cnt = 0;
    bit dist_mode = 1'b0;   // 0: squared Euclidean, 1: Manhattan
    logic [15:0] px[8], py[8];
    logic [7:0]  pl[8];

    knn_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .npoints(npoints),
        .test_x(test_x), .test_y(test_y),
        .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_x(pt_x), .pt_y(pt_y), .pt_label(pt_label),
        .dist_ax(dist_ax), .dist_bx(dist_bx), .dist_ay(dist_ay), .dist_by(dist_by),
        .dist_in(dist_in), .busy(busy), .done(done),
        .rd_idx(rd_idx), .rd_dist(rd_dist), .rd_label(rd_label), .rd_valid(rd_valid),
        .state_dbg(state_dbg)
`ifdef KNN_CTRL_VOTE_EN
        , .class_out(class_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dist_model(input logic [15:0] ax, bx, ay, by, input bit mode);
        int dx, dy;
        dx = int'(ax) - int'(bx);
        dy = int'(ay) - int'(by);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return mode ? 32'(dx + dy) : 32'(dx * dx + dy * dy);
    endfunction

    assign dist_in = dist_model(dist_ax, dist_bx, dist_ay, dist_by, dist_mode);

    function automatic logic [W-1:0] ent(input logic [31:0] d, input logic [7:0] l);
        return {1'b1, d, l};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push4(input logic [W-1:0] e0, e1, e2, e3);
        exp_q.push_back(e0); exp_q.push_back(e1);
        exp_q.push_back(e2); exp_q.push_back(e3);
    endtask

    task automatic push_cls(input logic [7:0] c);
`ifdef KNN_CTRL_VOTE_EN
        exp_cls.push_back(c);
`else
        if (c == 8'hxx) $display("unused");
`endif
    endtask

    // All driver tasks are entered and left at #1 after a rising edge.
    task automatic start_run(input logic [15:0] n, input logic [15:0] tx, ty);
        start = 1'b1; npoints = n; test_x = tx; test_y = ty;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("pt_ready_in_load", pt_ready, 0);
    endtask

    task automatic send_point(input logic [15:0] x, y, input logic [7:0] l);
        int cnt;
        pt_valid = 1'b1; pt_x = x; pt_y = y; pt_label = l;
        cnt = 0;
        while (!pt_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!pt_ready) begin
            n_cmp++; n_err++;
            $display("FAIL pt_ready_timeout: got 0 expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
        pt_valid = 1'b0;
    endtask

    // Called in the cycle after the last handshake (DIST).
    task automatic check_done_timing(input string nm);
        @(posedge clk); #1;
        check({nm, "_done_in_insert"}, done, 0);
        repeat (VD) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        check({nm, "_done_set"}, done, 1);
        check({nm, "_busy_in_done"}, busy, 1);
        @(posedge clk); #1;
        check({nm, "_busy_clear"}, busy, 0);
        check({nm, "_done_sticky"}, done, 1);
    endtask

    task automatic run_points(input string nm, input int n);
        start_run(16'(n), 16'd0, 16'd0);
        for (int i = 0; i < n; i++) send_point(px[i], py[i], pl[i]);
        check_done_timing(nm);
    endtask

    initial begin : monitor
        logic done_prev;
        logic rise;
        int seen;
        logic [W-1:0] act;
        done_prev = 1'b0;
        seen = 0;
        forever begin
            @(negedge clk);
            rise = done && !done_prev;
            done_prev = done;
            if (rise || req_cnt != seen) begin
                seen = req_cnt;
                for (int i = 0; i < K; i++) begin
                    rd_idx = 2'(i);
                    #1;
                    act = {rd_valid, rd_dist, rd_label};
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL slot%0d: got %0h expected none queued", i, act);
                    end else begin
                        check($sformatf("slot%0d", i), 64'(act), 64'(exp_q.pop_front()));
                    end
                end
`ifdef KNN_CTRL_VOTE_EN
                if (rise) begin
                    if (exp_cls.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL class_out: got %0d expected none queued", class_out);
                    end else begin
                        check("class_out", 64'(class_out), 64'(exp_cls.pop_front()));
                    end
                end
`endif
            end
        end
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pt_ready", pt_ready, 0);
        check("rst_operands", {dist_ax, dist_bx, dist_ay, dist_by}, 0);
        check("rst_state", state_dbg, 0);
`ifdef KNN_CTRL_VOTE_EN
        check("rst_class_out", class_out, 0);
`endif
        push4(EMPTY, EMPTY, EMPTY, EMPTY);
        req_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Three points, squared distance; a start pulse mid-run must be ignored.
        dist_mode = 1'b0;
        push4(ent(2, 2), ent(25, 1), ent(100, 3), EMPTY);
        push_cls(2);
        start_run(16'd3, 16'd0, 16'd0);
        @(posedge clk); #1;
        check("pt_ready_t2", pt_ready, 1);
        send_point(3, 4, 1);
        check("pt_ready_h1", pt_ready, 0);
        start = 1'b1; npoints = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("pt_ready_h2", pt_ready, 0);
        check("busy_ignored_start", busy, 1);
        @(posedge clk); #1;
        check("pt_ready_h3", pt_ready, 1);
        send_point(1, 1, 2);
        send_point(6, 8, 3);
        check("operand_a", {dist_ax, dist_ay}, 0);
        check("operand_b", {dist_bx, dist_by}, {16'd6, 16'd8});
        check_done_timing("run3");

        // Equal distances keep arrival order.
        push4(ent(1, 5), ent(1, 6), EMPTY, EMPTY);
        push_cls(5);
        px[0] = 1; py[0] = 0; pl[0] = 5;
        px[1] = 0; py[1] = 1; pl[1] = 6;
        run_points("tie", 2);

        // Six points, Manhattan distance: the 50 point is evicted, the 60 point dropped.
        dist_mode = 1'b1;
        push4(ent(10, 14), ent(20, 13), ent(30, 12), ent(40, 11));
        push_cls(14);
        px[0] = 50; px[1] = 40; px[2] = 30; px[3] = 20; px[4] = 10; px[5] = 60;
        for (int i = 0; i < 6; i++) begin py[i] = 0; pl[i] = 8'(10 + i); end
        run_points("six", 6);

        // Zero points: done two cycles after start, no pt_ready.
        push4(EMPTY, EMPTY, EMPTY, EMPTY);
        push_cls(0);
        start_run(16'd0, 16'd0, 16'd0);
        check("np0_done_t1", done, 0);
        @(posedge clk); #1;
        check("np0_done_t2", done, 1);
        check("np0_pt_ready", pt_ready, 0);
        @(posedge clk); #1;
        check("np0_busy_clear", busy, 0);
        check("np0_pt_ready_idle", pt_ready, 0);

        // Reset after 2 of 5 points.
        start_run(16'd5, 16'd0, 16'd0);
        send_point(5, 0, 1);
        send_point(3, 0, 2);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_pt_ready", pt_ready, 0);
        check("midrst_state", state_dbg, 0);
        push4(EMPTY, EMPTY, EMPTY, EMPTY);
        req_cnt++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Vote patterns: labels by rank 7,3,3,7 then 3,3,7,9.
        push4(ent(1, 7), ent(2, 3), ent(3, 3), ent(4, 7));
        push_cls(7);
        px[0] = 3; pl[0] = 3; px[1] = 1; pl[1] = 7; px[2] = 4; pl[2] = 7; px[3] = 2; pl[3] = 3;
        for (int i = 0; i < 4; i++) py[i] = 0;
        run_points("vote_tie", 4);

        push4(ent(1, 3), ent(2, 3), ent(3, 7), ent(4, 9));
        push_cls(3);
        px[0] = 2; pl[0] = 3; px[1] = 1; pl[1] = 3; px[2] = 3; pl[2] = 7; px[3] = 4; pl[3] = 9;
        run_points("vote_major", 4);

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/knn_ctrl.md
# knn_ctrl

Sequencer for the KNN distance datapath. It latches a test point and then streams N training points through an external `dist_core` instance over a valid/ready handshake. For each training point it drives the distance operands, captures the resulting distance, and keeps a sorted list of the K nearest points with their labels. It sits between the register-mapped software interface and `dist_core`, and replaces the ad-hoc load state machine in `knn_core`.

## Interface
- `DATA_W`, 16: coordinate width.
- `DIST_W`, 32: width of the distance returned by `dist_core`.
- `LABEL_W`, 8: training-point label width.
- `K`, 4: number of neighbours kept (≥1). `IDX_W` = `$clog2(K)`, minimum 1.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a run. Ignored while `busy`.
- `npoints`, in, 16: training-point count, sampled on `start`.
- `test_x`, `test_y`, in, DATA_W each: test point, sampled on `start`.
- `pt_valid`, in, 1 / `pt_ready`, out, 1: training-point handshake.
- `pt_x`, `pt_y`, in, DATA_W each / `pt_label`, in, LABEL_W: training point, sampled when `pt_valid && pt_ready`.
- `dist_ax`, `dist_bx`, `dist_ay`, `dist_by`, out, DATA_W each: operands to `dist_core`. A = test point, B = training point.
- `dist_in`, in, DIST_W: combinational result from `dist_core`.
- `busy`, out, 1: a run is in progress.
- `done`, out, 1: sticky; set at the end of a run, cleared by the next accepted `start`.
- `rd_idx`, in, IDX_W: list read index. 0 is the nearest.
- `rd_dist`, out, DIST_W / `rd_label`, out, LABEL_W / `rd_valid`, out, 1: combinational read of slot `rd_idx`.

## Operation
- States:
  - IDLE: `start` goes to LOAD.
  - LOAD: clears all slots, latches the test point and `npoints`, clears `pt_cnt`. Goes to DONE if `npoints`=0, else to WAIT.
  - WAIT: `pt_ready`=1. On handshake, registers the point and goes to DIST.
  - DIST: operands are stable from registers. Samples `dist_in` into `d_reg`, then goes to INSERT.
  - INSERT: single-cycle parallel insert, increments `pt_cnt`. Goes to DONE when `pt_cnt+1==npoints`, else to WAIT.
  - DONE: sets `done`, goes to IDLE. With `KNN_CTRL_VOTE_EN`, routes through VOTE first.
- Slot contents: `{valid, dist, label}`. On clear, valid=0 and dist=all-ones.
- Insert rule: the new point goes to the first slot i where `!valid[i] || d_reg < dist[i]`. Comparison is unsigned and strict, so an equal distance keeps the earlier point ahead. Slots i..K-2 shift down one place. If no slot qualifies, the point is dropped. The slot-K-1 entry is evicted when everything shifts.
- `busy` = state ≠ IDLE. `pt_ready` is 1 only in WAIT.
- Operand outputs hold their last registered values outside DIST.
- `pt_cnt` is 16 bits. `npoints`=65535 is legal with no wrap.
- Reads are combinational and valid in any state. During a run they show intermediate list contents.

## Timing
- Reset values: `pt_ready`, `busy`, `done`, `rd_valid` = 0. Operands = 0. All slots invalid with dist all-ones. `rd_label` = 0. `class_out` = 0.
- `start` at cycle t: `busy` at t+1, `pt_ready` at t+2 (WAIT).
- Point handshake at cycle h: DIST at h+1, INSERT at h+2, slot update visible at h+3, next `pt_ready` at h+3. Maximum throughput is one point per 3 cycles.
- Last INSERT at cycle c: `done`=1 and `busy`=1 at c+1 (DONE state), `busy`=0 at c+2.
- `npoints`=0: `done` rises 2 cycles after `start`.
- A `start` pulse while `busy` is ignored, and the list is not cleared.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values. No partial results are kept.

## Configuration
- `KNN_CTRL_VOTE_EN` defined:
  - Adds output `class_out` (LABEL_W) and a VOTE state between the last INSERT and DONE.
  - VOTE takes K cycles. Cycle j counts how many valid slots share slot j's label.
  - `class_out` is the label with the highest count. On a tie, the nearer slot wins.
  - `class_out` holds its value until the next `start`. `done` is delayed by K cycles.
- Undefined: no `class_out` port, no VOTE state, and `done` timing is as above.

## Test plan
- Reset mid-run (after 2 of 5 points) → next cycle `busy`=0, `done`=0, `pt_ready`=0, all `rd_valid`=0.
- K=4, test (0,0), squared-distance model; points (3,4,L1), (1,1,L2), (6,8,L3) → slots 0..2 = 2/L2, 25/L1, 100/L3; slot 3 invalid; `done` 1 cycle after the 3rd INSERT.
- Points (1,0,L5) then (0,1,L6), both distance 1 → slot 0 = L5, slot 1 = L6.
- 6 points at distances 50, 40, 30, 20, 10, 60 → slots = 10, 20, 30, 40; the 50 and 60 points are gone.
- `npoints`=0 → `done`=1 two cycles after `start`, `pt_ready` never asserted. A second `start` while `busy` → ignored.
- VOTE_EN, K=4, labels by rank L7, L3, L3, L7 → `class_out`=7 (tie, nearer wins). Labels L3, L3, L7, L9 → `class_out`=3. `done` delayed by 4 cycles.
